// File: rtl/alu_ctrl_pkg.sv
// alu_ctrl_pkg
//   Shared definitions for the ALU command sequencer: FSM state encoding,
//   command opcodes, the divide function code and the default result timeout.
package alu_ctrl_pkg;

  localparam int         DATA_WIDTH_DEF    = 8;
  localparam int         RES_TIMEOUT_DEF   = 4;
  localparam logic [7:0] CMD_ALU_OPER_DEF  = 8'hCC;  // CC, A, B, FUNC
  localparam logic [7:0] CMD_ALU_NOPER_DEF = 8'hDD;  // DD, FUNC (reuse A/B)
  localparam logic [3:0] FUNC_DIV          = 4'b0011;

  typedef enum logic [2:0] {
    ST_IDLE,
    ST_GET_A,
    ST_GET_B,
    ST_GET_FUNC,
    ST_EXEC,
    ST_WAIT_RES,
    ST_TX_LO,
    ST_TX_HI
  } state_e;

endpackage

// File: rtl/alu_res_timer.sv
// alu_res_timer
//   Loadable down-counter that bounds the wait for the ALU result.
//   Ports:
//     clk, reset   clock and synchronous active-high reset
//     load_i       load load_val_i (asserted in EXEC)
//     dec_i        count down one step (asserted in WAIT_RES)
//     load_val_i   reload value
//     expired_o    counter has reached zero
module alu_res_timer #(
  parameter int WIDTH = 2
) (
  input  logic             clk,
  input  logic             reset,
  input  logic             load_i,
  input  logic             dec_i,
  input  logic [WIDTH-1:0] load_val_i,
  output logic             expired_o
);

  logic [WIDTH-1:0] cnt_q;

  always_ff @(posedge clk) begin
    if (reset) begin
      cnt_q <= '0;
    end else if (load_i) begin
      cnt_q <= load_val_i;
    end else if (dec_i && (cnt_q != '0)) begin
      cnt_q <= cnt_q - 1'b1;
    end
  end

  assign expired_o = (cnt_q == '0);

endmodule

// File: rtl/alu_cmd_ctrl.sv
// alu_cmd_ctrl
//   Byte-stream command sequencer for the 8-bit ALU. Parses CC/DD command
//   frames from RX, issues one ALU enable per command, captures the 16-bit
//   result and returns it low byte first on a valid/ready TX interface.
//   Optional macro ALU_DIV_ZERO_CHK_EN: a divide with B == 0 is not issued;
//   the result becomes 16'hFFFF and err_out pulses.
//   Ports:
//     clk, reset                 clock, synchronous active-high reset
//     rx_data_in/rx_valid_in     received byte and its one-cycle strobe
//     alu_a_out/b_out/func_out   operands and function to the ALU
//     alu_en_out                 one-cycle ALU enable
//     alu_data_in/alu_valid_in   ALU result and its valid
//     tx_data_out/valid/ready    result byte handshake towards TX
//     busy_out                   any state other than IDLE
//     err_out                    one-cycle error pulse
module alu_cmd_ctrl
  import alu_ctrl_pkg::*;
#(
  parameter int                  DATA_WIDTH    = DATA_WIDTH_DEF,
  parameter int                  RES_WIDTH     = 2 * DATA_WIDTH,
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_OPER  = DATA_WIDTH'(CMD_ALU_OPER_DEF),
  parameter logic [DATA_WIDTH-1:0] CMD_ALU_NOPER = DATA_WIDTH'(CMD_ALU_NOPER_DEF),
  parameter int                  RES_TIMEOUT   = RES_TIMEOUT_DEF
) (
  input  logic                  clk,
  input  logic                  reset,
  input  logic [DATA_WIDTH-1:0] rx_data_in,
  input  logic                  rx_valid_in,
  output logic [DATA_WIDTH-1:0] alu_a_out,
  output logic [DATA_WIDTH-1:0] alu_b_out,
  output logic [3:0]            alu_func_out,
  output logic                  alu_en_out,
  input  logic [RES_WIDTH-1:0]  alu_data_in,
  input  logic                  alu_valid_in,
  output logic [DATA_WIDTH-1:0] tx_data_out,
  output logic                  tx_valid_out,
  input  logic                  tx_ready_in,
  output logic                  busy_out,
  output logic                  err_out
);

  // Timer counts RES_TIMEOUT-1 .. 0, giving RES_TIMEOUT cycles in WAIT_RES.
  localparam int TMR_W = (RES_TIMEOUT > 1) ? $clog2(RES_TIMEOUT) : 1;

  state_e                state_q, state_d;
  logic [DATA_WIDTH-1:0] a_q, a_d, b_q, b_d;
  logic [3:0]            func_q, func_d;
  logic [RES_WIDTH-1:0]  res_q, res_d;
  logic                  err_q, err_d;
  logic                  tmr_load, tmr_dec, tmr_expired;
  logic                  div_zero;

`ifdef ALU_DIV_ZERO_CHK_EN
  assign div_zero = (func_q == FUNC_DIV) && (b_q == '0);
`else
  assign div_zero = 1'b0;
`endif

  alu_res_timer #(
    .WIDTH (TMR_W)
  ) u_timer (
    .clk        (clk),
    .reset      (reset),
    .load_i     (tmr_load),
    .dec_i      (tmr_dec),
    .load_val_i (TMR_W'(RES_TIMEOUT - 1)),
    .expired_o  (tmr_expired)
  );

  always_ff @(posedge clk) begin
    if (reset) begin
      state_q <= ST_IDLE;
      a_q     <= '0;
      b_q     <= '0;
      func_q  <= '0;
      res_q   <= '0;
      err_q   <= 1'b0;
    end else begin
      state_q <= state_d;
      a_q     <= a_d;
      b_q     <= b_d;
      func_q  <= func_d;
      res_q   <= res_d;
      err_q   <= err_d;
    end
  end

  always_comb begin
    state_d  = state_q;
    a_d      = a_q;
    b_d      = b_q;
    func_d   = func_q;
    res_d    = res_q;
    err_d    = 1'b0;
    tmr_load = 1'b0;
    tmr_dec  = 1'b0;
    case (state_q)
      ST_IDLE: begin
        if (rx_valid_in) begin
          if (rx_data_in == CMD_ALU_OPER)       state_d = ST_GET_A;
          else if (rx_data_in == CMD_ALU_NOPER) state_d = ST_GET_FUNC;
          else                                  err_d   = 1'b1;
        end
      end
      ST_GET_A: begin
        if (rx_valid_in) begin
          a_d     = rx_data_in;
          state_d = ST_GET_B;
        end
      end
      ST_GET_B: begin
        if (rx_valid_in) begin
          b_d     = rx_data_in;
          state_d = ST_GET_FUNC;
        end
      end
      ST_GET_FUNC: begin
        if (rx_valid_in) begin
          func_d  = rx_data_in[3:0];
          state_d = ST_EXEC;
        end
      end
      // From here until back in IDLE any RX byte is dropped and flagged.
      ST_EXEC: begin
        err_d = rx_valid_in;
        if (div_zero) begin
          res_d   = '1;
          err_d   = 1'b1;
          state_d = ST_TX_LO;
        end else begin
          tmr_load = 1'b1;
          state_d  = ST_WAIT_RES;
        end
      end
      ST_WAIT_RES: begin
        err_d   = rx_valid_in;
        tmr_dec = 1'b1;
        // A result arriving in the final timer cycle still wins.
        if (alu_valid_in) begin
          res_d   = alu_data_in;
          state_d = ST_TX_LO;
        end else if (tmr_expired) begin
          res_d   = '0;
          err_d   = 1'b1;
          state_d = ST_TX_LO;
        end
      end
      ST_TX_LO: begin
        err_d = rx_valid_in;
        if (tx_ready_in) state_d = ST_TX_HI;
      end
      ST_TX_HI: begin
        err_d = rx_valid_in;
        if (tx_ready_in) state_d = ST_IDLE;
      end
      default: state_d = ST_IDLE;
    endcase
  end

  always_comb begin
    tx_data_out = '0;
    if (state_q == ST_TX_LO)      tx_data_out = res_q[DATA_WIDTH-1:0];
    else if (state_q == ST_TX_HI) tx_data_out = res_q[RES_WIDTH-1:DATA_WIDTH];
  end

  assign tx_valid_out = (state_q == ST_TX_LO) || (state_q == ST_TX_HI);
  assign alu_en_out   = (state_q == ST_EXEC) && !div_zero;
  assign alu_a_out    = a_q;
  assign alu_b_out    = b_q;
  assign alu_func_out = func_q;
  assign busy_out     = (state_q != ST_IDLE);
  assign err_out      = err_q;

endmodule
